// File: rtl/stage_stream.sv
// Stage loader: streams ROM obstacle descriptors into a windowed circular buffer,
// retires scrolled-off blocks, registers per-pixel hit/hazard. Build macro: STAGE_LOOP_EN.
module stage_stream #(
  parameter int POS_W     = 16,
  parameter int BLK_BITS  = 4*POS_W,
  parameter int ADDRW     = 5,
  parameter int STG_DEPTH = 8,
  parameter int NBUF      = 10,
  parameter int MAP_W     = 16,
  parameter int CORDW     = 16,
  parameter int H_RES     = 800,
  parameter int V_RES     = 600,
  parameter int STAGE_LEN = 4096
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [MAP_W-1:0]        i_map_x,
  input  logic signed [CORDW-1:0] i_sx,
  input  logic signed [CORDW-1:0] i_sy,
  input  logic [BLK_BITS-1:0]     i_data,
  output logic                    o_rd_en,
  output logic [ADDRW-1:0]        o_addr,
  output logic                    o_ready,
  output logic                    o_drawing,
  output logic                    o_hazard,
  output logic                    o_done,
  output logic                    o_overflow
);

  localparam int PXW = MAP_W + 1;
  localparam int MW1 = (PXW > POS_W) ? PXW : POS_W;
  localparam int MW2 = (MW1 > CORDW) ? MW1 : CORDW;
  localparam int CW  = ((MW2 > 16) ? MW2 : 16) + 2;
  localparam int IW  = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int NW  = $clog2(NBUF + 1);

  if (NBUF < 2 || STG_DEPTH < 1 || STG_DEPTH > (1 << ADDRW) ||
      BLK_BITS != 4*POS_W || STAGE_LEN < 0) begin : g_param_check
    $error("stage_stream: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, PRIME, PLAY, DONE} state_t;
  state_t state;

  logic [POS_W-1:0] b_left   [NBUF];
  logic [POS_W-1:0] b_right  [NBUF];
  logic [POS_W-1:0] b_height [NBUF];
  logic [1:0]       b_stat   [NBUF];
  logic [NBUF-1:0]  b_vld;
  logic [IW-1:0]    head, tail;
  logic [NW-1:0]    count;

  logic             pend, stage_end, have_new;
  logic [POS_W-1:0] pend_off, loop_off, newest_left;

  // Bottom blocks taller than the screen clamp to a full column.
  function automatic logic [CW-1:0] bot_thresh(input logic [POS_W-1:0] h);
    if (CW'(h) >= CW'(V_RES)) return '0;
    return CW'(V_RES) - CW'(h);
  endfunction

  function automatic logic slot_hit(input logic [POS_W-1:0] l, r, h,
                                    input logic top, input logic [CW-1:0] px, sy);
    if (px < CW'(l) || px > CW'(r)) return 1'b0;
    if (top) return sy <= CW'(h);
    return sy >= bot_thresh(h);
  endfunction

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(NBUF-1)) ? '0 : p + IW'(1);
  endfunction

  logic [CW-1:0]    map_c, edge_x;
  logic             past_edge, fetch_st, want, room, rt;
  logic [POS_W-1:0] d_left, d_right, d_height;
  logic [1:0]       d_stat;
  logic             stat_unused;

  assign map_c     = CW'(i_map_x);
  assign edge_x    = map_c + CW'(H_RES);
  assign past_edge = have_new && (CW'(newest_left) > edge_x);
  assign fetch_st  = (state == PRIME) || ((state == PLAY) && !past_edge);
  assign want      = fetch_st && !pend && !stage_end;
  assign room      = (count < NW'(NBUF));
  assign o_rd_en   = want && room;
  assign rt        = (state == PLAY) && b_vld[head] && (CW'(b_right[head]) < map_c);

  assign d_left      = i_data[4*POS_W-1 -: POS_W] + pend_off;
  assign d_right     = i_data[3*POS_W-1 -: POS_W] + pend_off;
  assign d_height    = i_data[2*POS_W-1 -: POS_W];
  assign d_stat      = i_data[1:0];
  assign stat_unused = ^i_data[POS_W-1:2];

  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_ready     <= 1'b0;
      o_done      <= 1'b0;
      o_overflow  <= 1'b0;
      o_addr      <= '0;
      pend        <= 1'b0;
      pend_off    <= '0;
      loop_off    <= '0;
      stage_end   <= 1'b0;
      have_new    <= 1'b0;
      newest_left <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      b_vld       <= '0;
      for (int i = 0; i < NBUF; i++) begin
        b_left[i]   <= '0;
        b_right[i]  <= '0;
        b_height[i] <= '0;
        b_stat[i]   <= '0;
      end
    end else begin
      pend <= o_rd_en;
      if (o_rd_en) begin
        pend_off <= loop_off;
        if (o_addr == ADDRW'(STG_DEPTH-1)) begin
`ifdef STAGE_LOOP_EN
          o_addr   <= '0;
          loop_off <= loop_off + POS_W'(STAGE_LEN);
`else
          o_addr    <= o_addr + ADDRW'(1);
          stage_end <= 1'b1;
`endif
        end else begin
          o_addr <= o_addr + ADDRW'(1);
        end
      end
      if (want && !room) o_overflow <= 1'b1;

      if (pend) begin
        b_left[tail]   <= d_left;
        b_right[tail]  <= d_right;
        b_height[tail] <= d_height;
        b_stat[tail]   <= d_stat;
        b_vld[tail]    <= 1'b1;
        tail           <= ptr_inc(tail);
        have_new       <= 1'b1;
        newest_left    <= d_left;
      end
      if (rt) begin
        b_vld[head] <= 1'b0;
        head        <= ptr_inc(head);
      end
      if (pend && !rt)      count <= count + NW'(1);
      else if (!pend && rt) count <= count - NW'(1);

      // Restart clears last so it overrides the datapath updates above.
      case (state)
        IDLE, DONE: if (i_start) begin
          state       <= PRIME;
          o_ready     <= 1'b0;
          o_done      <= 1'b0;
          o_overflow  <= 1'b0;
          o_addr      <= '0;
          loop_off    <= '0;
          stage_end   <= 1'b0;
          have_new    <= 1'b0;
          newest_left <= '0;
          head        <= '0;
          tail        <= '0;
          count       <= '0;
          b_vld       <= '0;
        end
        PRIME: if (past_edge || stage_end) begin
          state   <= PLAY;
          o_ready <= 1'b1;
        end
        PLAY: if (stage_end && !pend && count == '0) begin
          state  <= DONE;
          o_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [PXW-1:0] px_p0;
  logic                  coord_ok_p0, show_p0, hit_p0, haz_p0;
  logic [CW-1:0]         pxc_p0, syc_p0;

  assign px_p0       = $signed({1'b0, i_map_x}) + $signed(PXW'(i_sx));
  assign coord_ok_p0 = !px_p0[PXW-1] && !i_sy[CORDW-1];
  assign pxc_p0      = CW'($unsigned(px_p0));
  assign syc_p0      = CW'($unsigned(i_sy));
  assign show_p0     = (state == PLAY) || (state == DONE);

  always_comb begin
    hit_p0 = 1'b0;
    haz_p0 = 1'b0;
    for (int i = 0; i < NBUF; i++) begin
      if (b_vld[i] && coord_ok_p0 &&
          slot_hit(b_left[i], b_right[i], b_height[i], b_stat[i][0], pxc_p0, syc_p0)) begin
        hit_p0 = 1'b1;
        if (b_stat[i][1]) haz_p0 = 1'b1;
      end
    end
  end

  // p0 -> p1: registered hit result, one pixel behind the coordinate inputs
  always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drawing <= 1'b0;
      o_hazard  <= 1'b0;
    end else begin
      o_drawing <= show_p0 && hit_p0;
      o_hazard  <= show_p0 && haz_p0;
    end
  end

endmodule

// File: tb/tb_stage_stream.sv
// Directed bench for stage_stream: reset, priming, hit table, retire/DONE, overflow.
module tb_stage_stream;

  localparam int POS_W = 16;
  localparam int BB    = 4*POS_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance (NBUF=10, 8 blocks)
  logic              m_start, m_rd_en, m_ready, m_drawing, m_hazard, m_done, m_ovf;
  logic [15:0]       m_map_x;
  logic signed [15:0] m_sx, m_sy;
  logic [BB-1:0]     m_data;
  logic [4:0]        m_addr;
  logic [BB-1:0]     m_rom [32];
  logic [4:0]        m_rd_q [$];

  // overflow instance (NBUF=2, 5 blocks)
  logic              v_start, v_rd_en, v_ready, v_drawing, v_hazard, v_done, v_ovf;
  logic [15:0]       v_map_x;
  logic signed [15:0] v_sx, v_sy;
  logic [BB-1:0]     v_data;
  logic [4:0]        v_addr;
  logic [BB-1:0]     v_rom [32];
  int                v_reads;

  stage_stream #(.STG_DEPTH(8), .NBUF(10)) u_main (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_start(m_start), .i_map_x(m_map_x),
    .i_sx(m_sx), .i_sy(m_sy), .i_data(m_data), .o_rd_en(m_rd_en), .o_addr(m_addr),
    .o_ready(m_ready), .o_drawing(m_drawing), .o_hazard(m_hazard), .o_done(m_done),
    .o_overflow(m_ovf));

  stage_stream #(.STG_DEPTH(5), .NBUF(2)) u_ovf (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_start(v_start), .i_map_x(v_map_x),
    .i_sx(v_sx), .i_sy(v_sy), .i_data(v_data), .o_rd_en(v_rd_en), .o_addr(v_addr),
    .o_ready(v_ready), .o_drawing(v_drawing), .o_hazard(v_hazard), .o_done(v_done),
    .o_overflow(v_ovf));

  // ROM models: one-cycle read latency
  always @(posedge clk) begin
    if (m_rd_en) begin
      m_data <= m_rom[m_addr];
      m_rd_q.push_back(m_addr);
    end
    if (v_rd_en) begin
      v_data  <= v_rom[v_addr];
      v_reads <= v_reads + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BB-1:0] blk(input int l, r, h, s);
    return {16'(l), 16'(r), 16'(h), 16'(s)};
  endfunction

  typedef struct {
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    logic               draw;
    logic               haz;
  } vec_t;
  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // block 1: bottom h=200; block 3: hazard, h=700 (clamped); block 5: top h=200
    for (int i = 0; i < 32; i++) begin
      m_rom[i] = '0;
      v_rom[i] = '0;
    end
    for (int i = 0; i < 8; i++) m_rom[i] = blk(i*100, i*100 + 50, 0, 0);
    m_rom[1] = blk(100, 150, 200, 0);
    m_rom[3] = blk(300, 350, 700, 2);
    m_rom[5] = blk(500, 550, 200, 1);
    for (int i = 0; i < 5; i++) v_rom[i] = blk(i*10, i*10 + 100, 600, 2);

    vecs[0]  = '{16'sd120, 16'sd450, 1'b1, 1'b0};
    vecs[1]  = '{16'sd120, 16'sd399, 1'b0, 1'b0};
    vecs[2]  = '{16'sd520, 16'sd200, 1'b1, 1'b0};
    vecs[3]  = '{16'sd520, 16'sd201, 1'b0, 1'b0};
    vecs[4]  = '{16'sd320, 16'sd0,   1'b1, 1'b1};
    vecs[5]  = '{16'sd320, 16'sd599, 1'b1, 1'b1};
    vecs[6]  = '{16'sd100, 16'sd400, 1'b1, 1'b0};
    vecs[7]  = '{16'sd150, 16'sd599, 1'b1, 1'b0};
    vecs[8]  = '{16'sd151, 16'sd599, 1'b0, 1'b0};
    vecs[9]  = '{16'sd0,   16'sd599, 1'b0, 1'b0};
    vecs[10] = '{-16'sd5,  16'sd450, 1'b0, 1'b0};
    vecs[11] = '{16'sd120, -16'sd1,  1'b0, 1'b0};
    vecs[12] = '{16'sd350, 16'sd300, 1'b1, 1'b1};
    vecs[13] = '{16'sd351, 16'sd300, 1'b0, 1'b0};

    rst_n = 1'b0;
    m_start = 1'b0; m_map_x = '0; m_sx = '0; m_sy = '0;
    v_start = 1'b0; v_map_x = '0; v_sx = 16'sd5; v_sy = 16'sd599;
    v_reads = 0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", m_rd_en, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_ready", m_ready, 0);
    chk("rst_done", m_done, 0);
    chk("rst_ovf", m_ovf, 0);
    chk("rst_draw", {m_drawing, m_hazard}, 0);
    rst_n = 1'b1;

    // reset during PRIME with a read outstanding
    @(negedge clk) m_start = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!m_rd_en && cyc < 20);
    chk("prime_first_rd", m_rd_en, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_start = 1'b0;
    #1;
    chk("midrst_addr", m_addr, 0);
    chk("midrst_outs", {m_rd_en, m_ready, m_done, m_ovf, m_drawing, m_hazard}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_fetch", {m_rd_en, m_ready}, 0);
    m_rd_q.delete();

    // priming: 8 reads at 0..7, then PLAY
    @(negedge clk) m_start = 1'b1;
    @(negedge clk) m_start = 1'b0;
    cyc = 0;
    while (!m_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk("prime_ready", m_ready, 1);
    chk("prime_done", m_done, 0);
    chk("prime_nreads", m_rd_q.size(), 8);
    if (m_rd_q.size() == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("prime_addr[%0d]", i), m_rd_q[i], i);
    repeat (3) @(negedge clk);
    chk("prime_no_extra", m_rd_q.size(), 8);

    // hit table, map_x = 0
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      m_sx = vecs[i].sx;
      m_sy = vecs[i].sy;
      @(posedge clk); #1;
      chk($sformatf("hit_draw[%0d]", i), m_drawing, vecs[i].draw);
      chk($sformatf("hit_haz[%0d]", i), m_hazard, vecs[i].haz);
    end

    // one-cycle latency: output follows the previous edge's sample
    @(negedge clk); m_sx = 16'sd120; m_sy = 16'sd450;
    @(posedge clk); #1;
    chk("lat_hit", m_drawing, 1);
    m_sy = 16'sd100;
    #2;
    chk("lat_hold", m_drawing, 1);
    @(posedge clk); #1;
    chk("lat_miss", m_drawing, 0);

    // retire everything, one per cycle, then DONE
    @(negedge clk);
    m_map_x = 16'd800; m_sx = -16'sd680; m_sy = 16'sd450;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!m_done && cyc < 40);
    chk("done_flag", m_done, 1);
    chk("done_latency_ok", (cyc >= 9 && cyc <= 10), 1);
    @(negedge clk);
    chk("done_ready", m_ready, 1);
    chk("done_draw", {m_drawing, m_hazard}, 0);
    chk("done_ovf", m_ovf, 0);

    // restart from DONE
    m_rd_q.delete();
    m_start = 1'b1;
    @(negedge clk) m_start = 1'b0;
    chk("restart_done", {m_done, m_ready}, 0);
    cyc = 0;
    while (m_rd_q.size() == 0 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("restart_nreads", (m_rd_q.size() > 0), 1);
    if (m_rd_q.size() > 0) chk("restart_addr0", m_rd_q[0], 0);

    // overflow: NBUF=2, all blocks inside window
    @(negedge clk) v_start = 1'b1;
    @(negedge clk) v_start = 1'b0;
    cyc = 0;
    while (!v_ovf && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ovf_set", v_ovf, 1);
    repeat (20) @(negedge clk);
    chk("ovf_sticky", v_ovf, 1);
    chk("ovf_reads", v_reads, 2);
    chk("ovf_prime_draw", {v_drawing, v_hazard}, 0);
    chk("ovf_ready_done", {v_ready, v_done}, 0);
    rst_n = 1'b0;
    #1;
    chk("ovf_rst_clear", v_ovf, 0);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
